rv32_mod_bus_arbiter: RTL

Two-requester arbiter sharing the single external memory bus of the rv32imc_ss core between the instruction-fetch port and the load/store unit. One transaction at a time is granted and held until the bus acknowledges or errors. Priority alternates after each completion so neither port starves. Sits between the HART's fetch/LSU interfaces and the external data bus.

---
 rtl/rv32_pkg.sv | 23 ++
 rtl/rv32_mod_arb_timeout.sv | 32 +++
 rtl/rv32_mod_bus_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared types for the rv32imc_ss memory-side blocks.
// Arbiter state encoding, bus command bundle and defaults.
package rv32_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_INSTR,
        ARB_DATA
    } arb_state_t;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_cmd_t;

    localparam bus_cmd_t BUS_CMD_IDLE = '0;

endpackage

// File: rtl/rv32_mod_arb_timeout.sv
// Bus watchdog for the fetch/LSU arbiter.
// Counts busy cycles without a bus response; expired marks the last one.
module rv32_mod_arb_timeout
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // The cycle whose increment would reach the limit is the expiring one
    assign expired = run & (cnt == LIMIT);

    // Cycle counter, restarted on every grant or state change
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rv32_mod_bus_arbiter.sv
// Fetch/LSU arbiter for the single external memory bus.
// Optional bus watchdog enabled by defining RV32_ARB_TIMEOUT_EN.
module rv32_mod_bus_arbiter
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data_o,
    output logic        instr_ack,
    output logic        instr_err,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_data_i,
    output logic [31:0] data_data_o,
    output logic        data_ack,
    output logic        data_err,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack,
    input  logic        bus_err,
    output logic        busy
);

    arb_state_t state;
    arb_state_t state_d;
    logic       last;
    logic       last_d;
    logic       in_instr;
    logic       in_data;
    logic       tmo_expired;
    logic       rsp_err;
    logic       rsp_ack;
    logic       done;
    bus_cmd_t   cmd;

    assign in_instr = (state == ARB_INSTR);
    assign in_data  = (state == ARB_DATA);
    assign busy     = in_instr | in_data;

    // Error wins when ack and err coincide
    assign rsp_err = bus_err | tmo_expired;
    assign rsp_ack = bus_ack & ~rsp_err;
    assign done    = busy & (bus_ack | rsp_err);

`ifdef RV32_ARB_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_run;

    assign tmo_clear = (state_d != state);
    assign tmo_run   = busy & ~bus_ack & ~bus_err;

    rv32_mod_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmo_clear),
        .run    (tmo_run),
        .expired(tmo_expired)
    );
`else
    // Without the watchdog a grant only ends on ack, err or abort
    assign tmo_expired = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

    // Next grant: alternate on ties, hand over directly on completion
    always_comb begin
        state_d = state;
        last_d  = last;
        unique case (state)
            ARB_IDLE: begin
                if (instr_req && data_req) begin
                    state_d = last ? ARB_INSTR : ARB_DATA;
                end else if (instr_req) begin
                    state_d = ARB_INSTR;
                end else if (data_req) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_INSTR: begin
                if (done) begin
                    last_d  = 1'b0;
                    state_d = data_req ? ARB_DATA : ARB_IDLE;
                end else if (!instr_req) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_DATA: begin
                if (done) begin
                    last_d  = 1'b1;
                    state_d = instr_req ? ARB_INSTR : ARB_IDLE;
                end else if (!data_req) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Grant state and priority bit; instr wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_d;
            last  <= last_d;
        end
    end

    // Route the granted port onto the bus
    always_comb begin
        cmd = BUS_CMD_IDLE;
        unique case (1'b1)
            in_instr: begin
                cmd.req  = instr_req;
                cmd.wr   = 1'b0;
                cmd.be   = 4'hF;
                cmd.addr = instr_addr;
                cmd.data = 32'h0;
            end
            in_data: begin
                cmd.req  = data_req;
                cmd.wr   = data_wr;
                cmd.be   = data_be;
                cmd.addr = data_addr;
                cmd.data = data_data_i;
            end
            default: begin
                cmd = BUS_CMD_IDLE;
            end
        endcase
    end

    assign bus_req    = cmd.req;
    assign bus_wr     = cmd.wr;
    assign bus_be     = cmd.be;
    assign bus_addr   = cmd.addr;
    assign bus_data_o = cmd.data;

    assign instr_data_o = bus_data_i;
    assign data_data_o  = bus_data_i;

    assign instr_ack = in_instr & rsp_ack;
    assign instr_err = in_instr & rsp_err;
    assign data_ack  = in_data & rsp_ack;
    assign data_err  = in_data & rsp_err;

endmodule
